fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of Instruction_Memory.
- Owns the program counter and drives the byte address into the instruction memory. That memory returns the instruction combinationally in the same cycle.
- Captures each {pc, instruction} pair into a small FIFO and presents it to decode over a valid/ready handshake.
- Handles sequential PC+4 advance, back-pressure from decode, and redirect (branch/jump) with queue flush.

---
 rtl/fetch_unit.sv | 91 +++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory combinationally
// and queues {pc, instruction} pairs toward decode over a valid/ready handshake.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_target,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  logic [31:0]      pc_p0;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      q_pc_p1    [DEPTH];
  logic [31:0]      q_instr_p1 [DEPTH];
  logic             vld_p1;
  logic             pop;
  logic             push;

  assign imem_addr = pc_p0;
  assign vld_p1    = (count != '0);
  assign pop       = vld_p1 & out_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push      = fetch_en & ~redirect_valid & ((count < FULL) | pop);

  // Stage p0 -> p1: PC advance and queue bookkeeping
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_p0  <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc_p0  <= align_word(redirect_target);
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_p0  <= pc_inc(pc_p0);
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage is data only; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc_p1[wr_ptr]    <= pc_p0;
      q_instr_p1[wr_ptr] <= imem_data;
    end
  end

  // Stage p1 output: head of queue, zeroed when empty
  assign out_valid = vld_p1;
  assign out_pc    = vld_p1 ? q_pc_p1[rd_ptr]    : '0;
  assign out_instr = vld_p1 ? q_instr_p1[rd_ptr] : '0;
  assign q_count   = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues the PCs expected at decode,
// a negedge monitor pops and compares on every handshake.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [1:0]  q_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .q_count(q_count)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // Instruction memory model: combinational read
  assign imem_data = instr_of(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Monitor: every handshake seen before an edge must match the scoreboard head
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("FAIL xfer_unexpected: got pc=%h instr=%h want none", out_pc, out_instr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_pc !== e || out_instr !== instr_of(e)) begin
          bad = bad + 1;
          $display("FAIL xfer: got pc=%h instr=%h want pc=%h instr=%h",
                   out_pc, out_instr, e, instr_of(e));
        end
      end
    end
  end

  initial begin
    reset = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_target = '0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_count", {30'd0, q_count}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);

    // Streaming fetch with decode always ready
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    fetch_en = 1'b1; out_ready = 1'b1;
    tick();
    chk("first_valid", {31'd0, out_valid}, 32'd1);
    chk("first_pc", out_pc, 32'h0);
    chk("first_instr", out_instr, instr_of(32'h0));
    tick(); tick(); tick();
    fetch_en = 1'b0;
    tick();
    chk("stream_count", {30'd0, q_count}, 32'd0);
    chk("stream_addr", imem_addr, 32'h10);
    tick();
    chk("hold_addr", imem_addr, 32'h10);

    // Back-pressure fills the queue and freezes the PC
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    fetch_en = 1'b1; out_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("full_count", {30'd0, q_count}, 32'd2);
      chk("full_addr", imem_addr, 32'h8);
    end
    out_ready = 1'b1;
    tick();
    chk("full_pushpop_count", {30'd0, q_count}, 32'd2);
    fetch_en = 1'b0;
    tick(); tick();
    chk("drain_count", {30'd0, q_count}, 32'd0);
    chk("drain_addr", imem_addr, 32'hC);

    // Redirect while full discards pc=0,4 and aligns the target
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    tick(); tick();
    chk("pre_redir_count", {30'd0, q_count}, 32'd2);
    redirect_valid = 1'b1; redirect_target = 32'h2E;
    tick();
    chk("redir_count", {30'd0, q_count}, 32'd0);
    chk("redir_addr", imem_addr, 32'h2C);
    chk("redir_valid", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b0; out_ready = 1'b1;
    exp_q.push_back(32'h2C);
    tick();
    fetch_en = 1'b0;
    tick();
    chk("redir_drain", {30'd0, q_count}, 32'd0);

    // Redirect coinciding with a pop: head transfers, pc=4 entry vanishes
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    tick(); tick();
    exp_q.push_back(32'h0);
    redirect_valid = 1'b1; redirect_target = 32'h100; out_ready = 1'b1;
    tick();
    chk("redir_pop_count", {30'd0, q_count}, 32'd0);
    chk("redir_pop_addr", imem_addr, 32'h100);
    redirect_valid = 1'b0;
    exp_q.push_back(32'h100);
    tick();
    fetch_en = 1'b0;
    tick();

    // PC wrap from the top of the address space
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC; fetch_en = 1'b1;
    tick();
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    tick();
    chk("wrap_addr1", imem_addr, 32'h0);
    chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
    tick();
    fetch_en = 1'b0;
    tick();
    chk("wrap_count", {30'd0, q_count}, 32'd0);

    // Reset beats a simultaneous redirect with a full queue
    fetch_en = 1'b1; out_ready = 1'b0;
    tick(); tick();
    chk("pre_rst_count", {30'd0, q_count}, 32'd2);
    reset = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h500;
    tick();
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_count", {30'd0, q_count}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_pc", out_pc, 32'd0);
    chk("mid_rst_instr", out_instr, 32'd0);
    reset = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
    exp_q.push_back(32'h0);
    tick();
    fetch_en = 1'b0;
    tick(); tick();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
